// File: rtl/mem_server_pkg.sv
// Shared constants and types for the TOY main-memory server and its banks.
package mem_server_pkg;
  localparam int MEM_RPORTS       = 2;
  localparam int BANKS            = 2;
  localparam int ROW_W            = 7;
  localparam int ADDR_W           = ROW_W + 1;
  localparam int DATA_W           = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = $clog2(STARVE_LIMIT_DEF + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } port_state_e;

  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/mem_server_bank.sv
// One 128x16 bank of the interleaved TOY memory: single port, synchronous
// read and write, read data appears the cycle after an enabled read.
module mem_server_bank
  import mem_server_pkg::*;
(
  input  logic              clk_i,
  input  logic              i_en,
  input  logic              i_wen,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ROW_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_en) begin
      if (i_wen) r_mem[i_row] <= i_wdata;
      else       r_rdata      <= r_mem[i_row];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_server.sv
// TOY main-memory responder: fetch read ports plus one load/store rw port,
// arbitrated every cycle onto two address-interleaved banks (bank = addr[0]).
module mem_server
  import mem_server_pkg::*;
#(
  parameter int RPORTS       = MEM_RPORTS,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic [RPORTS-1:0]              i_r_val,
  input  logic [RPORTS-1:0][ADDR_W-1:0]  i_r_addr,
  output logic [RPORTS-1:0]              o_r_rdy,
  output logic [RPORTS-1:0][DATA_W-1:0]  o_r_rdata,
  input  logic                           i_rw_val,
  input  logic                           i_rw_wen,
  input  logic [ADDR_W-1:0]              i_rw_addr,
  input  logic [DATA_W-1:0]              i_rw_wdata,
  output logic                           o_rw_rdy,
  output logic [DATA_W-1:0]              o_rw_rdata,
  output logic [RPORTS:0]                o_dbg_state
);
  // Handshake: the master holds val/addr until rdy. rdy comes in the cycle
  // after the grant; a val drop or addr change in that cycle aborts the access
  // and the port re-arbitrates immediately with the new request.
  localparam int NP    = RPORTS + 1;
  localparam int RW    = RPORTS;
  localparam int PTR_W = (RPORTS > 1) ? $clog2(RPORTS) : 1;
  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);

  logic [NP-1:0]     w_val, w_hit, w_req, w_gnt;
  logic [ADDR_W-1:0] w_addr       [NP];
  logic [DATA_W-1:0] w_live       [NP];
  logic [RPORTS-1:0] w_rreq       [BANKS];
  logic [BANKS-1:0]  w_rwreq, w_rwgnt, w_rgnt;
  logic [PTR_W-1:0]  w_win        [BANKS];
  logic [ROW_W-1:0]  w_row        [BANKS];
  logic [DATA_W-1:0] w_bank_rdata [BANKS];

  port_state_e       r_state [NP];
  logic [ADDR_W-1:0] r_laddr [NP];
  logic [DATA_W-1:0] r_hold  [NP];
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [PTR_W-1:0]  r_ptr   [BANKS];
  logic [CNT_W-1:0]  r_cnt   [BANKS];

  assign w_val = {i_rw_val, i_r_val};

  for (genvar p = 0; p < RPORTS; p++) begin : g_rmap
    assign w_addr[p] = i_r_addr[p];
  end
  assign w_addr[RW] = i_rw_addr;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_hit[p]  = (r_state[p] == WAIT) && w_val[p] && (w_addr[p] == r_laddr[p]);
      w_req[p]  = w_val[p] && !w_hit[p];
      w_live[p] = w_bank_rdata[r_laddr[p][0]];
    end
    if (r_wen) w_live[RW] = r_wdata;
  end

  // rw wins a bank unless the starvation count has reached its limit while a
  // read port is waiting on that bank; reads share by round robin.
  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < BANKS; b++) begin
      w_rreq[b] = '0;
      for (int p = 0; p < RPORTS; p++)
        w_rreq[b][p] = w_req[p] && (w_addr[p][0] == b[0]);
      w_rwreq[b] = w_req[RW] && (w_addr[RW][0] == b[0]);
      w_win[b]   = '0;
      for (int k = RPORTS - 1; k >= 0; k--)
        if (w_rreq[b][(int'(r_ptr[b]) + k) % RPORTS])
          w_win[b] = PTR_W'((int'(r_ptr[b]) + k) % RPORTS);
      w_rwgnt[b] = w_rwreq[b] && !((|w_rreq[b]) && (r_cnt[b] == CNT_W'(STARVE_LIMIT)));
      w_rgnt[b]  = (|w_rreq[b]) && !w_rwgnt[b];
      if (w_rwgnt[b]) w_gnt[RW] = 1'b1;
      if (w_rgnt[b])  w_gnt[w_win[b]] = 1'b1;
      w_row[b] = w_rwgnt[b] ? w_addr[RW][ADDR_W-1:1] : w_addr[w_win[b]][ADDR_W-1:1];
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    mem_server_bank u_bank (
      .clk_i   (clk_i),
      .i_en    (w_rwgnt[b] | w_rgnt[b]),
      .i_wen   (w_rwgnt[b] & i_rw_wen),
      .i_row   (w_row[b]),
      .i_wdata (i_rw_wdata),
      .o_rdata (w_bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int p = 0; p < NP; p++) begin
        r_state[p] <= IDLE;
        r_laddr[p] <= '0;
        r_hold[p]  <= '0;
      end
      r_wen   <= 1'b0;
      r_wdata <= '0;
      for (int b = 0; b < BANKS; b++) begin
        r_ptr[b] <= '0;
        r_cnt[b] <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (w_gnt[p]) begin
          r_state[p] <= WAIT;
          r_laddr[p] <= w_addr[p];
        end else begin
          r_state[p] <= IDLE;
        end
        if (w_hit[p]) r_hold[p] <= w_live[p];
      end
      if (w_gnt[RW]) begin
        r_wen   <= i_rw_wen;
        r_wdata <= i_rw_wdata;
      end
      for (int b = 0; b < BANKS; b++) begin
        if (w_rgnt[b])
          r_ptr[b] <= (w_win[b] == PTR_W'(RPORTS - 1)) ? '0 : w_win[b] + 1'b1;
        if (w_rgnt[b] || !(|w_rreq[b])) r_cnt[b] <= '0;
        else                            r_cnt[b] <= r_cnt[b] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < RPORTS; p++) begin
      o_r_rdy[p]   = w_hit[p];
      o_r_rdata[p] = w_hit[p] ? w_live[p] : r_hold[p];
    end
    o_rw_rdy   = w_hit[RW];
    o_rw_rdata = w_hit[RW] ? w_live[RW] : r_hold[RW];
    for (int p = 0; p < NP; p++) o_dbg_state[p] = (r_state[p] == WAIT);
  end
endmodule
